// File: rtl/fifo_ctrl_param_if.sv
// Request/RAM-control/status bundle between the FIFO requesters and fifo_ctrl_param.
// Optional overflow/underflow flags are present only with FIFO_CTRL_ERR_FLAGS_EN.
interface fifo_ctrl_param_if #(parameter int ADDR_W = 4);
    logic              clear;
    logic              mode;
    logic              we;
    logic              re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [ADDR_W:0]   count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              almost_full;
    logic              almost_empty;
    logic              done;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic              overflow;
    logic              underflow;

    modport master (output clear, mode, we, re,
                    input  mem_we, mem_waddr, mem_re, mem_raddr, count, fifo_full,
                           fifo_empty, almost_full, almost_empty, done, overflow, underflow);
    modport slave  (input  clear, mode, we, re,
                    output mem_we, mem_waddr, mem_re, mem_raddr, count, fifo_full,
                           fifo_empty, almost_full, almost_empty, done, overflow, underflow);
`else
    modport master (output clear, mode, we, re,
                    input  mem_we, mem_waddr, mem_re, mem_raddr, count, fifo_full,
                           fifo_empty, almost_full, almost_empty, done);
    modport slave  (input  clear, mode, we, re,
                    output mem_we, mem_waddr, mem_re, mem_raddr, count, fifo_full,
                           fifo_empty, almost_full, almost_empty, done);
`endif
endinterface

// File: rtl/fifo_ctrl_param.sv
// FIFO controller for an external dual-port RAM: burst (fill-then-drain) or stream mode.
// Strobes are combinational; rejected requests are dropped. Macro FIFO_CTRL_ERR_FLAGS_EN adds sticky overflow/underflow.
module fifo_ctrl_param #(
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input logic               clk,
    input logic               rst,
    fifo_ctrl_param_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FILL, DRAIN, STREAM} state_t;

    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_NEAR = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] AF_LV    = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_LV    = AE_LEVEL[ADDR_W:0];

    state_t          state, state_nxt;
    logic            done_q, done_nxt;
    logic [ADDR_W:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0] count;
    logic            full, empty;
    logic            wr_acc, rd_acc;

    // The extra pointer bit disambiguates full from empty when the address bits match.
    assign count = wr_ptr - rd_ptr;
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign wr_acc = bus.we && !full && !bus.clear && (state == FILL || state == STREAM);
    assign rd_acc = bus.re && !empty && !bus.clear && (state == DRAIN || state == STREAM);

    assign bus.mem_we       = wr_acc;
    assign bus.mem_re       = rd_acc;
    assign bus.mem_waddr    = wr_ptr[ADDR_W-1:0];
    assign bus.mem_raddr    = rd_ptr[ADDR_W-1:0];
    assign bus.count        = count;
    assign bus.fifo_full    = full;
    assign bus.fifo_empty   = empty;
    assign bus.almost_full  = (count >= AF_LV);
    assign bus.almost_empty = (count <= AE_LV);
    assign bus.done         = done_q;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE:    state_nxt = bus.mode ? STREAM : FILL;
            FILL:    if (wr_acc && count == CNT_NEAR) state_nxt = DRAIN;
            DRAIN:   if (rd_acc && count == PTR_ONE) begin
                         state_nxt = IDLE;
                         done_nxt  = 1'b1;
                     end
            STREAM:  state_nxt = STREAM;
            default: state_nxt = IDLE;
        endcase
        if (bus.clear) begin
            state_nxt = IDLE;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
        end
    end

    // IDLE holds the pointers at zero so every burst or stream session starts at address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.clear || state == IDLE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.clear) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.we && full && (state == FILL || state == STREAM))   overflow_q  <= 1'b1;
            if (bus.re && empty && (state == DRAIN || state == STREAM)) underflow_q <= 1'b1;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Directed self-checking bench for fifo_ctrl_param (ADDR_W=4, AF_LEVEL=14, AE_LEVEL=2).
module tb_fifo_ctrl_param;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    logic [3:0] ew, er;

    fifo_ctrl_param_if #(.ADDR_W(4)) bus ();

    fifo_ctrl_param #(.ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", bus.fifo_empty); end
        n_cmp++; if (bus.fifo_full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", bus.fifo_full); end
        n_cmp++; if (bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL rst_ae: got %b want 1", bus.almost_empty); end
        n_cmp++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL rst_af: got %b want 0", bus.almost_full); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.mem_re !== 1'b0) begin n_fail++; $display("FAIL rst_mem_re: got %b want 0", bus.mem_re); end
        tick();
        rst = 1'b0;
        bus.mode = 1'b0;
        bus.we = 1'b1;
        #1;
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_first_we: got %b want 0", bus.mem_we); end
        tick();
    endtask

    // Enters with the FSM in FILL and we=1.
    task automatic test_burst;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_cmp++; if (bus.mem_we !== 1'b1 || bus.mem_waddr !== 4'(i)) begin
                n_fail++; $display("FAIL burst_wr%0d: got we=%b addr=%0d want we=1 addr=%0d", i, bus.mem_we, bus.mem_waddr, i);
            end
            tick();
        end
        #1;
        n_cmp++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL burst_count16: got %0d want 16", bus.count); end
        n_cmp++; if (bus.fifo_full !== 1'b1 || bus.almost_full !== 1'b1) begin
            n_fail++; $display("FAIL burst_full: got full=%b af=%b want 1 1", bus.fifo_full, bus.almost_full);
        end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL burst_wr17: got %b want 0", bus.mem_we); end
        bus.we = 1'b0;
        bus.re = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_cmp++; if (bus.mem_re !== 1'b1 || bus.mem_raddr !== 4'(i)) begin
                n_fail++; $display("FAIL burst_rd%0d: got re=%b addr=%0d want re=1 addr=%0d", i, bus.mem_re, bus.mem_raddr, i);
            end
            n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL burst_early_done%0d: got 1 want 0", i); end
            tick();
        end
        bus.re = 1'b0;
        #1;
        n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL burst_done: got %b want 1", bus.done); end
        n_cmp++; if (bus.fifo_empty !== 1'b1 || bus.count !== 5'd0) begin
            n_fail++; $display("FAIL burst_empty: got empty=%b count=%0d want 1 0", bus.fifo_empty, bus.count);
        end
        tick();
        #1;
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL burst_done_pulse: got %b want 0", bus.done); end
        tick();
    endtask

    task automatic enter_stream;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.mode = 1'b1;
        tick();
        ew = 4'd0;
        er = 4'd0;
    endtask

    task automatic test_stream_wrap;
        enter_stream();
        bus.we = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_cmp++; if (bus.mem_we !== 1'b1 || bus.mem_waddr !== ew) begin
                n_fail++; $display("FAIL wrap_wr%0d: got we=%b addr=%0d want we=1 addr=%0d", i, bus.mem_we, bus.mem_waddr, ew);
            end
            ew = ew + 4'd1;
            tick();
        end
        bus.we = 1'b0;
        bus.re = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_cmp++; if (bus.mem_re !== 1'b1 || bus.mem_raddr !== er) begin
                n_fail++; $display("FAIL wrap_rd%0d: got re=%b addr=%0d want re=1 addr=%0d", i, bus.mem_re, bus.mem_raddr, er);
            end
            er = er + 4'd1;
            tick();
        end
        bus.re = 1'b0;
        bus.we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++; if (bus.mem_waddr !== ew || bus.almost_empty !== (i <= 2)) begin
                n_fail++; $display("FAIL wrap_wr2_%0d: got addr=%0d ae=%b want addr=%0d ae=%b", i, bus.mem_waddr, bus.almost_empty, ew, (i <= 2));
            end
            ew = ew + 4'd1;
            tick();
        end
        #1;
        n_cmp++; if (bus.count !== 5'd8) begin n_fail++; $display("FAIL wrap_count8: got %0d want 8", bus.count); end
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL wrap_af_low%0d: got 1 want 0", 8 + i); end
            ew = ew + 4'd1;
            tick();
        end
        bus.we = 1'b0;
        #1;
        n_cmp++; if (bus.count !== 5'd14 || bus.almost_full !== 1'b1) begin
            n_fail++; $display("FAIL wrap_af14: got count=%0d af=%b want 14 1", bus.count, bus.almost_full);
        end
    endtask

    // Continues the stream session left at count 14.
    task automatic test_simultaneous;
        bus.re = 1'b1;
        for (int i = 0; i < 9; i++) begin
            er = er + 4'd1;
            tick();
        end
        bus.we = 1'b1;
        #1;
        n_cmp++; if (bus.count !== 5'd5 || bus.mem_we !== 1'b1 || bus.mem_re !== 1'b1) begin
            n_fail++; $display("FAIL sim5_strobes: got count=%0d we=%b re=%b want 5 1 1", bus.count, bus.mem_we, bus.mem_re);
        end
        tick();
        ew = ew + 4'd1;
        er = er + 4'd1;
        bus.we = 1'b0;
        bus.re = 1'b0;
        #1;
        n_cmp++; if (bus.count !== 5'd5 || bus.mem_waddr !== ew || bus.mem_raddr !== er) begin
            n_fail++; $display("FAIL sim5_after: got count=%0d wa=%0d ra=%0d want 5 %0d %0d", bus.count, bus.mem_waddr, bus.mem_raddr, ew, er);
        end
        bus.we = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        bus.re = 1'b1;
        #1;
        n_cmp++; if (bus.count !== 5'd16 || bus.mem_we !== 1'b0 || bus.mem_re !== 1'b1) begin
            n_fail++; $display("FAIL sim16_strobes: got count=%0d we=%b re=%b want 16 0 1", bus.count, bus.mem_we, bus.mem_re);
        end
        tick();
        bus.we = 1'b0;
        #1;
        n_cmp++; if (bus.count !== 5'd15) begin n_fail++; $display("FAIL sim16_after: got %0d want 15", bus.count); end
        for (int i = 0; i < 15; i++) tick();
        bus.we = 1'b1;
        #1;
        n_cmp++; if (bus.count !== 5'd0 || bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0) begin
            n_fail++; $display("FAIL sim0_strobes: got count=%0d we=%b re=%b want 0 1 0", bus.count, bus.mem_we, bus.mem_re);
        end
        tick();
        bus.we = 1'b0;
        bus.re = 1'b0;
        #1;
        n_cmp++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL sim0_after: got %0d want 1", bus.count); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL stream_done: got 1 want 0"); end
    endtask

    task automatic test_clear;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.mode = 1'b0;
        tick();
        bus.we = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        #1;
        n_cmp++; if (bus.count !== 5'd7) begin n_fail++; $display("FAIL clr_pre_count: got %0d want 7", bus.count); end
        bus.clear = 1'b1;
        #1;
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL clr_mem_we: got %b want 0", bus.mem_we); end
        tick();
        bus.clear = 1'b0;
        #1;
        n_cmp++; if (bus.count !== 5'd0 || bus.done !== 1'b0 || bus.mem_we !== 1'b0) begin
            n_fail++; $display("FAIL clr_after: got count=%0d done=%b we=%b want 0 0 0", bus.count, bus.done, bus.mem_we);
        end
        tick();
        #1;
        n_cmp++; if (bus.mem_we !== 1'b1 || bus.mem_waddr !== 4'd0) begin
            n_fail++; $display("FAIL clr_restart: got we=%b addr=%0d want 1 0", bus.mem_we, bus.mem_waddr);
        end
        bus.we = 1'b0;
        tick();
    endtask

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    task automatic test_err_flags;
        enter_stream();
        #1;
        n_cmp++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            n_fail++; $display("FAIL err_init: got ov=%b un=%b want 0 0", bus.overflow, bus.underflow);
        end
        bus.re = 1'b1;
        tick();
        bus.re = 1'b0;
        #1;
        n_cmp++; if (bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin
            n_fail++; $display("FAIL err_underflow: got ov=%b un=%b want 0 1", bus.overflow, bus.underflow);
        end
        bus.we = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        bus.we = 1'b0;
        #1;
        n_cmp++; if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
            n_fail++; $display("FAIL err_overflow: got ov=%b count=%0d want 1 16", bus.overflow, bus.count);
        end
        tick();
        #1;
        n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL err_ov_held: got 0 want 1"); end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        #1;
        n_cmp++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            n_fail++; $display("FAIL err_cleared: got ov=%b un=%b want 0 0", bus.overflow, bus.underflow);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_fail = 0;
        ew = 4'd0;
        er = 4'd0;
        rst = 1'b1;
        bus.clear = 1'b0;
        bus.mode = 1'b0;
        bus.we = 1'b0;
        bus.re = 1'b0;
        @(negedge clk);
        test_reset();
        test_burst();
        test_stream_wrap();
        test_simultaneous();
        test_clear();
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        test_err_flags();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_ctrl_param.md
Name: fifo_ctrl_param

Overview:
- Parametrised FIFO controller. Generates write/read addresses and strobes for an external dual-port RAM, plus status flags.
- Successor of the fixed fill-then-drain controller. Adds configurable depth, an occupancy count, almost-full/almost-empty flags, a synchronous clear, and a run-time mode select.
- Burst mode keeps the legacy fill-then-drain sequence. Stream mode allows concurrent read and write.
- Sits between the producer/consumer request logic and the FIFO storage RAM.

Parameters:
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries (ADDR_W >= 1).
- AF_LEVEL, 14, almost_full asserted when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous clear of pointers and FSM
- mode  in  1  0 = burst (fill-then-drain), 1 = stream
- we  in  1  write request
- re  in  1  read request
- mem_we  out  1  RAM write strobe (accepted write)
- mem_waddr  out  ADDR_W  RAM write address
- mem_re  out  1  RAM read strobe (accepted read); data arrives next cycle
- mem_raddr  out  ADDR_W  RAM read address
- count  out  ADDR_W+1  occupancy, 0..DEPTH
- fifo_full  out  1  count == DEPTH
- fifo_empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- done  out  1  one-cycle pulse at end of a burst drain

Behaviour:
- Pointers: wr_ptr and rd_ptr, each ADDR_W+1 bits, wrap modulo 2*DEPTH.
  - mem_waddr = wr_ptr[ADDR_W-1:0]; mem_raddr = rd_ptr[ADDR_W-1:0].
  - count = wr_ptr - rd_ptr, computed modulo 2**(ADDR_W+1).
  - Full when the pointer MSBs differ and the lower bits are equal; empty when the pointers are equal.
- All flags and count decode combinationally from the registered pointers.
- mem_we and mem_re are combinational: request AND accept condition. A pointer increments on the same clock edge as its accepted strobe.
- Reset (rst=1): state IDLE, pointers 0, done 0. Resulting outputs: count 0, fifo_empty 1, fifo_full 0, almost_empty 1, almost_full 0, mem_we 0, mem_re 0.
- FSM states:
  - IDLE: pointers forced to 0; no accepts. mode is sampled here, and the FSM always leaves after 1 cycle, to FILL if mode=0 or STREAM if mode=1.
  - FILL: write accepted if we=1 and not full; reads never accepted. Goes to DRAIN on the edge where count becomes DEPTH.
  - DRAIN: read accepted if re=1 and not empty; writes never accepted. On the edge where count becomes 0, goes to IDLE and done is registered high for exactly that one IDLE cycle.
  - STREAM: write accepted if we=1 and not full; read accepted if re=1 and not empty. Both may be accepted in the same cycle, in which case count is unchanged. STREAM is left only via rst or clear. done stays 0.
- Simultaneous requests at a boundary (STREAM):
  - Full with we&re: only the read is accepted, count becomes DEPTH-1.
  - Empty with we&re: only the write is accepted, count becomes 1.
- mode changes outside IDLE are ignored until the next IDLE.
- clear=1: mem_we and mem_re are forced to 0 that cycle. Next edge: pointers 0, state IDLE, done 0. rst has priority over clear.
- Rejected requests are dropped silently. Requesters must hold we/re until they see the corresponding strobe.

Optional Feature:
- Macro: FIFO_CTRL_ERR_FLAGS_EN.
- Defined: adds output ports overflow and underflow (1 bit each, reset 0).
  - overflow sets sticky when we=1 while fifo_full=1 in FILL or STREAM.
  - underflow sets sticky when re=1 while fifo_empty=1 in DRAIN or STREAM.
  - Both are cleared only by rst or clear.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, defaults: pulse rst -> count=0, fifo_empty=1, fifo_full=0, almost_empty=1, done=0. The first post-reset cycle has mem_we=0 even with we=1.
- Burst, mode=0: 16 writes -> mem_waddr 0..15, fifo_full=1, count=16. A 17th write gives mem_we=0. Then 16 reads -> mem_raddr 0..15; done=1 for one cycle after the 16th read; fifo_empty=1.
- Stream wrap, mode=1: write 12, read 12, write 8 -> mem_waddr runs 12..15 then 0..3, count=8. almost_full=1 at count 14, almost_empty=0 above count 2.
- Stream simultaneous: we&re at count 5 -> count stays 5, both addresses advance. At count 16 -> only mem_re, count 15. At count 0 -> only mem_we, count 1.
- Clear mid-burst at count 7 -> next cycle count=0, state IDLE, done=0, mem_we=0 during the clear cycle.
- With FIFO_CTRL_ERR_FLAGS_EN: write at count 16 -> overflow=1 and held; read at count 0 -> underflow=1. After clear -> both 0.
